// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: assembles sof-framed serial words and
// queues them in a two-entry output FIFO with valid/ready delivery.
module sipo_rx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sof,
  output logic [WIDTH-1:0] out,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             busy,
  output logic             ovf,
  output logic             frm_err,
  input  logic             clr
);

  // Handshake: a word is transferred on every rising edge where out_vld and
  // out_rdy are both high; out is held stable while out_vld=1 and out_rdy=0.

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] slot;
  logic             slot_vld;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first_word;
  logic             last;
  logic             push;
  logic             pop;
  logic             ovf_set;
  logic             fe_set;

  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted    = {sr[WIDTH-2:0], sin};
      assign first_word = {{(WIDTH-1){1'b0}}, sin};
    end else begin : g_lsb
      assign shifted    = {sin, sr[WIDTH-1:1]};
      assign first_word = {sin, {(WIDTH-1){1'b0}}};
    end
  endgenerate

  // The last bit of a word always wins over a coincident sof.
  assign last    = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
  assign push    = last;
  assign pop     = out_vld && out_rdy;
  assign fe_set  = (state == SHIFT) && sof && !last;
  assign ovf_set = push && out_vld && slot_vld && !pop;
  assign busy    = (state == SHIFT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sof) begin
            sr    <= first_word;
            cnt   <= CW'(1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (last) begin
            sr    <= shifted;
            cnt   <= '0;
            state <= IDLE;
          end else if (sof) begin
            sr  <= first_word;
            cnt <= CW'(1);
          end else begin
            sr  <= shifted;
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // out is the FIFO head; slot is the second entry behind it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out      <= '0;
      out_vld  <= 1'b0;
      slot     <= '0;
      slot_vld <= 1'b0;
    end else if (pop) begin
      if (slot_vld) begin
        out <= slot;
        if (push) slot <= shifted;
        else      slot_vld <= 1'b0;
      end else if (push) begin
        out <= shifted;
      end else begin
        out_vld <= 1'b0;
      end
    end else if (push) begin
      if (!out_vld) begin
        out     <= shifted;
        out_vld <= 1'b1;
      end else if (!slot_vld) begin
        slot     <= shifted;
        slot_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf     <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      ovf     <= ovf_set | (ovf & ~clr);
      frm_err <= fe_set | (frm_err & ~clr);
    end
  end

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: MSB-first and LSB-first instances share stimulus and are
// compared every cycle against a queue-based model of framing and delivery.
module tb_sipo_rx;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sin = 1'b0;
  logic sof = 1'b0;
  logic out_rdy = 1'b0;
  logic clr = 1'b0;

  logic [W-1:0] out_m, out_l;
  logic vld_m, vld_l, busy_m, busy_l, ovf_m, ovf_l, fe_m, fe_l;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_lq[$];
  logic         bits[$];
  logic [W-1:0] m_out, l_out;
  logic         m_busy, m_ovf, m_fe;

  always #5 clk = ~clk;

  sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sof(sof),
    .out(out_m), .out_vld(vld_m), .out_rdy(out_rdy),
    .busy(busy_m), .ovf(ovf_m), .frm_err(fe_m), .clr(clr)
  );

  sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .sin(sin), .sof(sof),
    .out(out_l), .out_vld(vld_l), .out_rdy(out_rdy),
    .busy(busy_l), .ovf(ovf_l), .frm_err(fe_l), .clr(clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_lq.delete();
    bits.delete();
    m_out = '0; l_out = '0;
    m_busy = 1'b0; m_ovf = 1'b0; m_fe = 1'b0;
  endtask

  // One rising edge of behaviour, expressed as a bit list plus word queues.
  task automatic model_step(input logic s_sof, input logic s_sin, input logic s_rdy, input logic s_clr);
    logic         push, ovf_set, fe_set;
    logic [W-1:0] wm, wl;
    push = 1'b0; ovf_set = 1'b0; fe_set = 1'b0; wm = '0; wl = '0;
    if (!m_busy) begin
      if (s_sof) begin
        bits.delete(); bits.push_back(s_sin); m_busy = 1'b1;
      end
    end else if (bits.size() == W - 1) begin
      bits.push_back(s_sin); push = 1'b1; m_busy = 1'b0;
    end else if (s_sof) begin
      fe_set = 1'b1; bits.delete(); bits.push_back(s_sin);
    end else begin
      bits.push_back(s_sin);
    end
    if (push) begin
      for (int i = 0; i < W; i++) begin
        wm[W-1-i] = bits[i];
        wl[i]     = bits[i];
      end
    end
    if (exp_q.size() > 0 && s_rdy) begin
      void'(exp_q.pop_front());
      void'(exp_lq.pop_front());
    end
    if (push) begin
      if (exp_q.size() < 2) begin
        exp_q.push_back(wm);
        exp_lq.push_back(wl);
      end else begin
        ovf_set = 1'b1;
      end
    end
    m_ovf = ovf_set | (m_ovf & ~s_clr);
    m_fe  = fe_set  | (m_fe  & ~s_clr);
    if (exp_q.size() > 0) begin
      m_out = exp_q[0];
      l_out = exp_lq[0];
    end
  endtask

  task automatic check_all();
    logic mv;
    mv = (exp_q.size() > 0);
    chk("out_msb", out_m, m_out);
    chk("out_lsb", out_l, l_out);
    chk("vld_msb", vld_m, mv);
    chk("vld_lsb", vld_l, mv);
    chk("busy", {busy_m, busy_l}, {m_busy, m_busy});
    chk("ovf", {ovf_m, ovf_l}, {m_ovf, m_ovf});
    chk("frm_err", {fe_m, fe_l}, {m_fe, m_fe});
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic cycle(input logic c_sof, input logic c_sin, input logic c_rdy, input logic c_clr);
    sof = c_sof; sin = c_sin; out_rdy = c_rdy; clr = c_clr;
    @(posedge clk);
    model_step(c_sof, c_sin, c_rdy, c_clr);
    #1;
    check_all();
    @(negedge clk);
  endtask

  // Sends b[W-1] first.
  task automatic send_frame(input logic [W-1:0] b, input logic rdy);
    for (int i = W - 1; i >= 0; i--) cycle(i == W - 1, b[i], rdy, 1'b0);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0; sof = 1'b0; clr = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    chk("reset_out", out_m, 0);
    rst = 1'b1;

    // Single word, MSB first, consumer always ready.
    send_frame(4'b0111, 1'b1);
    chk("single_out", out_m, 4'b0111);
    chk("single_vld", vld_m, 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("single_popped", vld_m, 0);

    // Three back-to-back frames into a stalled consumer.
    send_frame(4'b0111, 1'b0);
    send_frame(4'b1010, 1'b0);
    send_frame(4'b1111, 1'b0);
    chk("b2b_ovf", ovf_m, 1);
    chk("b2b_head", out_m, 4'b0111);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("b2b_second", out_m, 4'b1010);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("b2b_drained", vld_m, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    chk("clr_ovf", ovf_m, 0);

    // Restart mid-frame.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(4'b0011, 1'b0);
    chk("midsof_err", fe_m, 1);
    chk("midsof_out", out_m, 4'b0011);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    chk("midsof_one_word", vld_m, 0);

    // Reset in the middle of a frame.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    do_reset();
    chk("rst_busy", busy_m, 0);
    send_frame(4'b1001, 1'b0);
    chk("rst_next", out_m, 4'b1001);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_one_word", vld_m, 0);

    // Full FIFO with a push and a pop in the same cycle.
    send_frame(4'b1100, 1'b0);
    send_frame(4'b0101, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("full_pp_ovf", ovf_m, 0);
    chk("full_pp_head", out_m, 4'b0101);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("full_pp_tail", out_m, 4'b0110);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // LSB-first ordering.
    send_frame(4'b1110, 1'b1);
    chk("lsb_out", out_l, 4'b0111);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      cycle($urandom_range(0, 4) == 0, 1'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
